// File: rtl/counter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer_pkg
// Purpose  : Shared types and constants for the counter sequencer slice.
//            State encoding of the sequencing FSM and the run-mode encoding
//            latched with start.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package counter_sequencer_pkg;

   // Sequencer states; encoding is fixed so it stays stable across the slice.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Run modes latched together with start.
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

endpackage : counter_sequencer_pkg
`default_nettype wire

// File: rtl/sync_up_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_up_counter
// Purpose  : WIDTH-bit synchronous up counter. Clear has priority over
//            enable; with neither asserted the value holds.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-low reset (clears q)
//            i_clr  - synchronous clear to zero (priority)
//            i_en   - increment by one
//            o_q    - current count
// Revision : 1.0 - initial release
// ============================================================================
module sync_up_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_q
);

   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= r_q + c_one;
      end
   end

   assign o_q = r_q;

endmodule : sync_up_counter
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer
// Purpose  : Control FSM sequencing a WIDTH-bit up counter. Latches a
//            terminal value and mode on start, counts/pauses/stops, strobes
//            tc on each terminal hit and reports one-shot completion via a
//            done_valid/done_ack handshake. Sole owner of the counter's
//            clear and enable.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-low reset
//            start      - begin a run (IDLE only)
//            stop       - abort, highest priority outside IDLE
//            pause      - level, freeze counting while high
//            mode       - 0 one-shot, 1 periodic (latched with start)
//            limit      - terminal count (latched with start)
//            count      - current counter value
//            busy       - high in RUN or HOLD
//            tc         - terminal-count strobe
//            done_valid - one-shot completion, high in DONE
//            done_ack   - consumer acknowledge of done_valid
// Revision : 1.0 - initial release
// ============================================================================
module counter_sequencer
   import counter_sequencer_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             mode,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc,
   output logic             done_valid,
   input  logic             done_ack
);

   state_t           r_state;
   logic [WIDTH-1:0] r_limit;
   logic             r_mode;
   logic             r_busy;
   logic             r_done_valid;

   logic             w_clr;
   logic             w_en;
   logic             w_at_limit;
   logic [WIDTH-1:0] w_count;

   assign w_at_limit = (w_count == r_limit);

   // Counter control. The terminal check precedes pause so a terminal hit
   // is never swallowed by a simultaneous pause request.
   always_comb begin
      w_clr = 1'b0;
      w_en  = 1'b0;
      case (r_state)
         ST_IDLE: w_clr = 1'b1;
         ST_RUN: begin
            if (stop) begin
               w_clr = 1'b1;
            end else if (w_at_limit) begin
               // One-shot holds the terminal value into DONE.
               w_clr = (r_mode == MODE_PERIODIC);
            end else if (!pause) begin
               w_en = 1'b1;
            end
         end
         ST_HOLD: w_clr = stop;
         ST_DONE: w_clr = stop | done_ack;
         default: w_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_limit      <= '0;
         r_mode       <= MODE_ONESHOT;
         r_busy       <= 1'b0;
         r_done_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_limit <= limit;
                  r_mode  <= mode;
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (w_at_limit) begin
                  if (r_mode == MODE_ONESHOT) begin
                     r_state      <= ST_DONE;
                     r_busy       <= 1'b0;
                     r_done_valid <= 1'b1;
                  end
               end else if (pause) begin
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (!pause) begin
                  r_state <= ST_RUN;
               end
            end
            ST_DONE: begin
               // start is deliberately ignored here, even alongside ack.
               if (stop || done_ack) begin
                  r_state      <= ST_IDLE;
                  r_done_valid <= 1'b0;
               end
            end
            default: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_done_valid <= 1'b0;
            end
         endcase
      end
   end

   sync_up_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_clr),
      .i_en  (w_en),
      .o_q   (w_count)
   );

   assign count      = w_count;
   assign busy       = r_busy;
   assign done_valid = r_done_valid;
   // Decoded purely from registers: state, counter and latched limit.
   assign tc         = (r_state == ST_RUN) && w_at_limit;

endmodule : counter_sequencer
`default_nettype wire
